muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle sequencer for the combinational M-extension datapath. It accepts one MUL/DIV/REM request at a time over a valid/ready handshake and holds the operands stable in registers for a configurable number of cycles. This makes the slow multiplier/divider paths legal multicycle paths. It then captures the result and presents it to the writeback stage with its own valid/ready handshake. It sits between the execute-stage issue logic and writeback, and stalls the pipeline while busy.

## Interface
- XLEN, 32, datapath width
- FPGA, 0, passed through to the datapath (behavioural vs DesignWare arithmetic)
- MUL_CYCLES, 2, EXEC cycles for funct3[2]==0 (MUL/MULH/MULHSU/MULHU); must be ≥1
- DIV_CYCLES, 8, EXEC cycles for funct3[2]==1 (DIV/DIVU/REM/REMU); must be ≥1
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- req_valid_i  in  1  request present
- req_ready_o  out  1  request accepted when high with req_valid_i
- req_in1_i  in  XLEN  rs1 operand
- req_in2_i  in  XLEN  rs2 operand
- req_funct3_i  in  3  M-extension funct3
- req_rd_i  in  5  destination register tag
- flush_i  in  1  kill any in-flight operation
- resp_valid_o  out  1  result available
- resp_ready_i  in  1  writeback consumes result
- resp_result_o  out  XLEN  result
- resp_rd_o  out  5  destination tag of result
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, EXEC, DONE.
- IDLE → EXEC on accept. Latch in1, in2, funct3, rd. Load the counter with (funct3[2] ? DIV_CYCLES : MUL_CYCLES) − 1.
- Divide-by-zero fast path: if funct3[2]==1 and in2==0, load 0 instead, so EXEC lasts one cycle.
- EXEC: decrement the counter each cycle. At count==0, write the datapath output to the result register and go to DONE.
- Result overrides applied at capture, per RISC-V:
  - DIV/DIVU by 0 → all ones.
  - REM/REMU by 0 → in1.
  - DIV of 0x80000000 by 0xFFFFFFFF → 0x80000000.
  - REM of 0x80000000 by 0xFFFFFFFF → 0.
- DONE: resp_valid_o is high. Hold result and rd until resp_ready_i.
  - Handshake with no new request → IDLE.
  - Handshake with req_valid_i in the same cycle → accept the new request and go directly to EXEC.
- req_ready_o = !rst_i && !flush_i && (state==IDLE || (state==DONE && resp_ready_i)). Combinational from resp_ready_i.
- resp_valid_o = (state==DONE) && !flush_i.
- flush_i in any state → IDLE next cycle:
  - pending result discarded;
  - no request accepted that cycle;
  - flush wins over a simultaneous response handshake (that handshake does not occur).
- Operand registers feed the datapath directly. They must not change during EXEC.
- Counter width: $clog2(DIV_CYCLES+1) (≥1 bit).

## Timing
- Reset values:
  - state IDLE; busy_o 0; resp_valid_o 0;
  - resp_result_o 0; resp_rd_o 0; operand/funct3/rd registers 0;
  - req_ready_o 0 while rst_i is high, 1 the cycle after.
- Reset mid-EXEC or mid-DONE → reset values next cycle; no response is ever produced for the aborted operation.
- Latency: with accept in cycle T and N EXEC cycles, resp_valid_o rises in T+N+1.
  - Default MUL: 3 cycles.
  - Default DIV: 9 cycles.
  - Divide-by-zero: 2 cycles.
- Throughput with resp_ready_i held high: one operation per N+1 cycles (back-to-back accept in the DONE cycle).
- busy_o is high from T+1 until the cycle after the final handshake or flush.
- Multicycle constraints: MUL_CYCLES / DIV_CYCLES from the operand and funct3 registers to the result register.

## Structure
- Shared package muldiv_pkg holds:
  - the state enum typedef (IDLE/EXEC/DONE);
  - default latency localparams.
- funct3 encodings come from the existing opcode header.
- One sub-module: the existing combinational datapath muldiv_unit.
  - Instantiate it with the registered operands and funct3.
  - Tie opcode/funct7 to the MULDIV encodings.
  - Leave is_muldiv_o unused.
- The sequencer adds only the FSM, counter, override logic and registers.

## Test plan
- MUL 7 × 0xFFFFFFFD (defaults), accept at T → resp_result_o=0xFFFFFFEB, resp_valid_o first high at T+3.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 at T+9. REM with the same operands → 0.
- DIVU 100 / 0 → 0xFFFFFFFF at T+2. REMU 100 / 0 → 0x64 at T+2.
- Backpressure and back-to-back:
  - Hold resp_ready_i low 5 cycles in DONE → result/rd stable, req_ready_o 0.
  - Raise resp_ready_i with a new MUL valid → accepted that cycle, next resp_valid_o 3 cycles later.
- Flush:
  - Assert flush_i in EXEC cycle 3 of a DIV → no resp_valid_o ever, IDLE next cycle; a new request the following cycle completes normally.
  - flush_i during a DONE+resp_ready_i cycle → no handshake counted.
- Assert rst_i mid-EXEC → all outputs at reset values next cycle; no stale response after release.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension multi-cycle sequencer.
//   - state_e          : sequencer FSM states
//   - DEF_*_CYCLES     : default EXEC-phase lengths for multiply and divide
//   - OPCODE/FUNCT7/F3 : RV32M encodings used to drive the datapath
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEF_MUL_CYCLES = 2;
    localparam int DEF_DIV_CYCLES = 8;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_unit.sv
// Combinational RV32M datapath (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Ports:
//   opcode_i, funct7_i : instruction fields, only used for is_muldiv_o
//   funct3_i           : operation select
//   in1_i, in2_i       : rs1 / rs2 operands
//   result_o           : raw arithmetic result (division by zero and signed
//                        overflow are not RISC-V corrected here)
//   is_muldiv_o        : opcode/funct7 decode an M-extension instruction
// FPGA selects between a single wide signed multiply and a magnitude
// multiply with sign fix-up; both give identical results.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int FPGA = 0
) (
    input  logic [6:0]      opcode_i,
    input  logic [6:0]      funct7_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] in1_i,
    input  logic [XLEN-1:0] in2_i,
    output logic [XLEN-1:0] result_o,
    output logic            is_muldiv_o
);

    logic              a_signed;
    logic              b_signed;
    logic [2*XLEN-1:0] product;

    assign a_signed = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU);
    assign b_signed = (funct3_i == F3_MULH);

    generate
        if (FPGA != 0) begin : g_mul_direct
            // Extend each operand by one bit so unsigned operands stay
            // positive inside a signed multiply.
            logic signed [XLEN:0]     a_ext;
            logic signed [XLEN:0]     b_ext;
            logic signed [2*XLEN-1:0] a_wide;
            logic signed [2*XLEN-1:0] b_wide;
            assign a_ext   = {a_signed & in1_i[XLEN-1], in1_i};
            assign b_ext   = {b_signed & in2_i[XLEN-1], in2_i};
            assign a_wide  = (2*XLEN)'(a_ext);
            assign b_wide  = (2*XLEN)'(b_ext);
            assign product = a_wide * b_wide;
        end else begin : g_mul_magnitude
            logic              a_neg;
            logic              b_neg;
            logic [XLEN-1:0]   a_mag;
            logic [XLEN-1:0]   b_mag;
            logic [2*XLEN-1:0] mag_prod;
            assign a_neg    = a_signed & in1_i[XLEN-1];
            assign b_neg    = b_signed & in2_i[XLEN-1];
            assign a_mag    = a_neg ? -in1_i : in1_i;
            assign b_mag    = b_neg ? -in2_i : in2_i;
            assign mag_prod = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
            assign product  = (a_neg ^ b_neg) ? -mag_prod : mag_prod;
        end
    endgenerate

    // Division works on magnitudes so the signed overflow case never reaches
    // a native signed divide; a zero divisor is replaced by 1 to keep the
    // operator well defined.
    logic            div_signed;
    logic            n_neg;
    logic            d_neg;
    logic [XLEN-1:0] n_mag;
    logic [XLEN-1:0] d_mag;
    logic [XLEN-1:0] d_safe;
    logic [XLEN-1:0] q_mag;
    logic [XLEN-1:0] r_mag;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;

    assign div_signed = !funct3_i[0];
    assign n_neg      = div_signed & in1_i[XLEN-1];
    assign d_neg      = div_signed & in2_i[XLEN-1];
    assign n_mag      = n_neg ? -in1_i : in1_i;
    assign d_mag      = d_neg ? -in2_i : in2_i;
    assign d_safe     = (d_mag == '0) ? {{(XLEN-1){1'b0}}, 1'b1} : d_mag;
    assign q_mag      = (d_mag == '0) ? '0 : n_mag / d_safe;
    assign r_mag      = (d_mag == '0) ? n_mag : n_mag % d_safe;
    assign quotient   = (n_neg ^ d_neg) ? -q_mag : q_mag;
    assign remainder  = n_neg ? -r_mag : r_mag;

    always_comb begin
        result_o = '0;
        case (funct3_i)
            F3_MUL:                       result_o = product[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: result_o = product[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              result_o = quotient;
            default:                      result_o = remainder;
        endcase
    end

    assign is_muldiv_o = (opcode_i == OPCODE_OP) && (funct7_i == FUNCT7_MULDIV);

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle sequencer around the combinational muldiv_unit.
// Accepts one request (valid/ready), holds operands in registers for
// MUL_CYCLES or DIV_CYCLES EXEC cycles, captures the result with the
// RISC-V divide-by-zero / overflow corrections, then presents it to
// writeback (valid/ready).
// Ports:
//   clk_i, rst_i                     : clock, synchronous active-high reset
//   req_valid_i/req_ready_o          : request handshake
//   req_in1_i, req_in2_i             : operands
//   req_funct3_i, req_rd_i           : operation and destination tag
//   flush_i                          : abort any in-flight operation
//   resp_valid_o/resp_ready_i        : response handshake
//   resp_result_o, resp_rd_o         : result and its destination tag
//   busy_o                           : sequencer not idle
// Timing: paths from in1_q/in2_q/funct3_q to result_q are multicycle
// paths of MUL_CYCLES / DIV_CYCLES; the operand registers only load on
// accept, never during EXEC.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int FPGA       = 0,
    parameter int MUL_CYCLES = DEF_MUL_CYCLES,
    parameter int DIV_CYCLES = DEF_DIV_CYCLES
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] req_in1_i,
    input  logic [XLEN-1:0] req_in2_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [4:0]      req_rd_i,
    input  logic            flush_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] resp_result_o,
    output logic [4:0]      resp_rd_o,
    output logic            busy_o
);

    // Sized for the longer of the two latencies so an oversized MUL_CYCLES
    // cannot overflow the counter.
    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [XLEN-1:0]  XMIN     = {1'b1, {(XLEN-1){1'b0}}};

    state_e            state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [XLEN-1:0]   in1_q,    in1_d;
    logic [XLEN-1:0]   in2_q,    in2_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q,     rd_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept;
    logic [XLEN-1:0]   dp_result;
    logic [XLEN-1:0]   capture;
    logic              is_muldiv_unused;

    muldiv_unit #(
        .XLEN (XLEN),
        .FPGA (FPGA)
    ) u_muldiv_unit (
        .opcode_i    (OPCODE_OP),
        .funct7_i    (FUNCT7_MULDIV),
        .funct3_i    (funct3_q),
        .in1_i       (in1_q),
        .in2_i       (in2_q),
        .result_o    (dp_result),
        .is_muldiv_o (is_muldiv_unused)
    );

    // RISC-V mandated results the raw datapath does not produce.
    always_comb begin
        capture = dp_result;
        if (funct3_q[2]) begin
            if (in2_q == '0) begin
                capture = funct3_q[1] ? in1_q : '1;
            end else if (!funct3_q[0] && (in1_q == XMIN) && (in2_q == '1)) begin
                capture = funct3_q[1] ? '0 : XMIN;
            end
        end
    end

    always_comb begin
        req_ready_o = !rst_i && !flush_i &&
                      ((state_q == IDLE) || ((state_q == DONE) && resp_ready_i));
        accept      = req_valid_i && req_ready_o;

        state_d  = state_q;
        cnt_d    = cnt_q;
        in1_d    = in1_q;
        in2_d    = in2_q;
        funct3_d = funct3_q;
        rd_d     = rd_q;
        result_d = result_q;

        case (state_q)
            IDLE: ;
            EXEC: begin
                if (cnt_q == '0) begin
                    result_d = capture;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accept is possible from IDLE or from DONE in the handshake cycle;
        // in the latter case the sequencer skips IDLE entirely.
        if (accept) begin
            state_d  = EXEC;
            in1_d    = req_in1_i;
            in2_d    = req_in2_i;
            funct3_d = req_funct3_i;
            rd_d     = req_rd_i;
            if (req_funct3_i[2] && (req_in2_i == '0)) begin
                cnt_d = '0;
            end else begin
                cnt_d = req_funct3_i[2] ? DIV_LOAD : MUL_LOAD;
            end
        end

        if (flush_i) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            in1_q    <= '0;
            in2_q    <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            funct3_q <= funct3_d;
            rd_q     <= rd_d;
            result_q <= result_d;
        end
    end

    assign resp_valid_o  = (state_q == DONE) && !flush_i;
    assign resp_result_o = result_q;
    assign resp_rd_o     = rd_q;
    assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed testbench for muldiv_sequencer with default parameters
// (MUL 2 EXEC cycles, DIV 8 EXEC cycles). Inputs change 1 time unit after
// the rising edge; outputs are sampled there too.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] req_in1_i;
    logic [31:0] req_in2_i;
    logic [2:0]  req_funct3_i;
    logic [4:0]  req_rd_i;
    logic        flush_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] resp_result_o;
    logic [4:0]  resp_rd_o;
    logic        busy_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .XLEN       (32),
        .FPGA       (0),
        .MUL_CYCLES (2),
        .DIV_CYCLES (8)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_in1_i     (req_in1_i),
        .req_in2_i     (req_in2_i),
        .req_funct3_i  (req_funct3_i),
        .req_rd_i      (req_rd_i),
        .flush_i       (flush_i),
        .resp_valid_o  (resp_valid_o),
        .resp_ready_i  (resp_ready_i),
        .resp_result_o (resp_result_o),
        .resp_rd_o     (resp_rd_o),
        .busy_o        (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request and let the next edge accept it; returns in cycle T+1.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        req_funct3_i = f3;
        req_in1_i    = a;
        req_in2_i    = b;
        req_rd_i     = rd;
        req_valid_i  = 1'b1;
        #1;
        check("req_ready_at_issue", 32'(req_ready_o), 32'd1);
        step();
        req_valid_i = 1'b0;
    endtask

    // Called in cycle T+1; lat ends as (first resp_valid cycle) - T.
    task automatic wait_resp(output int lat);
        lat = 1;
        while (!resp_valid_o && lat < 64) begin
            step();
            lat++;
        end
    endtask

    task automatic consume();
        resp_ready_i = 1'b1;
        #1;
        step();
        resp_ready_i = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int exp_lat);
        int lat;
        issue(f3, a, b, rd);
        wait_resp(lat);
        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_result"}, resp_result_o, exp);
        check({tag, "_rd"}, 32'(resp_rd_o), 32'(rd));
        $display("op %-9s a=%h b=%h rd=%0d -> result=%h rd=%0d latency=%0d",
                 tag, a, b, rd, resp_result_o, resp_rd_o, lat);
        consume();
        check({tag, "_idle_after"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  seen;

        rst_i        = 1'b1;
        req_valid_i  = 1'b0;
        req_in1_i    = '0;
        req_in2_i    = '0;
        req_funct3_i = '0;
        req_rd_i     = '0;
        flush_i      = 1'b0;
        resp_ready_i = 1'b0;

        // Reset values
        step(); step(); step();
        check("rst_req_ready", 32'(req_ready_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_resp_valid", 32'(resp_valid_o), 32'd0);
        check("rst_result", resp_result_o, 32'd0);
        check("rst_rd", 32'(resp_rd_o), 32'd0);
        rst_i = 1'b0;
        #1;
        check("rst_release_ready", 32'(req_ready_o), 32'd1);
        $display("reset released");

        // Arithmetic vectors
        run_op("MUL",      F3_MUL,    32'd7,        32'hFFFFFFFD, 5'd1,  32'hFFFFFFEB, 3);
        run_op("MULHU",    F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'hFFFFFFFE, 3);
        run_op("MULH",     F3_MULH,   32'd2,        32'h80000000, 5'd3,  32'hFFFFFFFF, 3);
        run_op("MULHSU",   F3_MULHSU, 32'hFFFFFFFE, 32'h80000000, 5'd4,  32'hFFFFFFFF, 3);
        run_op("MULHU2",   F3_MULHU,  32'hFFFFFFFE, 32'h80000000, 5'd5,  32'h7FFFFFFF, 3);
        run_op("DIV_OVF",  F3_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd6,  32'h80000000, 9);
        run_op("REM_OVF",  F3_REM,    32'h80000000, 32'hFFFFFFFF, 5'd7,  32'h00000000, 9);
        run_op("DIVU_Z",   F3_DIVU,   32'd100,      32'd0,        5'd8,  32'hFFFFFFFF, 2);
        run_op("REMU_Z",   F3_REMU,   32'd100,      32'd0,        5'd9,  32'h00000064, 2);
        run_op("DIV_NEG",  F3_DIV,    32'hFFFFFFF9, 32'd2,        5'd10, 32'hFFFFFFFD, 9);
        run_op("REM_NEG",  F3_REM,    32'hFFFFFFF9, 32'd2,        5'd11, 32'hFFFFFFFF, 9);
        run_op("DIV_Z",    F3_DIV,    32'hFFFFFFF9, 32'd0,        5'd12, 32'hFFFFFFFF, 2);
        run_op("REM_Z",    F3_REM,    32'hFFFFFFF9, 32'd0,        5'd13, 32'hFFFFFFF9, 2);
        run_op("DIVU_BIG", F3_DIVU,   32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h00000000, 9);
        run_op("REMU_BIG", F3_REMU,   32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h80000000, 9);

        // Backpressure in DONE, then back-to-back accept on the handshake
        issue(F3_MUL, 32'd3, 32'd4, 5'd20);
        wait_resp(lat);
        check("bp_latency", 32'(lat), 32'd3);
        req_funct3_i = F3_MUL;
        req_in1_i    = 32'd6;
        req_in2_i    = 32'd7;
        req_rd_i     = 5'd21;
        req_valid_i  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_result_hold", resp_result_o, 32'd12);
            check("bp_rd_hold", 32'(resp_rd_o), 32'd20);
            check("bp_req_ready_low", 32'(req_ready_o), 32'd0);
            check("bp_resp_valid", 32'(resp_valid_o), 32'd1);
            step();
        end
        resp_ready_i = 1'b1;
        #1;
        check("b2b_req_ready", 32'(req_ready_o), 32'd1);
        step();
        resp_ready_i = 1'b0;
        req_valid_i  = 1'b0;
        $display("backpressure: held 5 cycles, result=12 rd=20 consumed with new MUL accepted");
        wait_resp(lat);
        check("b2b_latency", 32'(lat), 32'd3);
        check("b2b_result", resp_result_o, 32'd42);
        check("b2b_rd", 32'(resp_rd_o), 32'd21);
        $display("op B2B_MUL  result=%h rd=%0d latency=%0d", resp_result_o, resp_rd_o, lat);
        consume();

        // Flush in EXEC cycle 3 of a DIV
        issue(F3_DIV, 32'd1000, 32'd10, 5'd22);
        step();
        step();
        flush_i = 1'b1;
        #1;
        check("flush_exec_resp_valid", 32'(resp_valid_o), 32'd0);
        check("flush_exec_req_ready", 32'(req_ready_o), 32'd0);
        step();
        flush_i = 1'b0;
        check("flush_exec_idle", 32'(busy_o), 32'd0);
        $display("flush: DIV aborted in EXEC cycle 3");
        run_op("MUL_POSTFL", F3_MUL, 32'd9, 32'd9, 5'd23, 32'd81, 3);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (resp_valid_o || busy_o) seen = 1'b1;
        end
        check("flush_no_stale_resp", 32'(seen), 32'd0);

        // Flush during DONE with resp_ready and a new request
        issue(F3_MUL, 32'd2, 32'd3, 5'd24);
        wait_resp(lat);
        check("fldone_latency", 32'(lat), 32'd3);
        resp_ready_i = 1'b1;
        flush_i      = 1'b1;
        req_funct3_i = F3_MUL;
        req_in1_i    = 32'd5;
        req_in2_i    = 32'd5;
        req_rd_i     = 5'd25;
        req_valid_i  = 1'b1;
        #1;
        check("fldone_resp_valid", 32'(resp_valid_o), 32'd0);
        check("fldone_req_ready", 32'(req_ready_o), 32'd0);
        step();
        resp_ready_i = 1'b0;
        flush_i      = 1'b0;
        req_valid_i  = 1'b0;
        check("fldone_idle", 32'(busy_o), 32'd0);
        check("fldone_no_resp", 32'(resp_valid_o), 32'd0);
        $display("flush: DONE handshake suppressed, no request accepted");

        // Reset mid-EXEC
        issue(F3_DIV, 32'd50, 32'd5, 5'd26);
        step();
        step();
        rst_i = 1'b1;
        step();
        check("rstx_busy", 32'(busy_o), 32'd0);
        check("rstx_resp_valid", 32'(resp_valid_o), 32'd0);
        check("rstx_result", resp_result_o, 32'd0);
        check("rstx_rd", 32'(resp_rd_o), 32'd0);
        check("rstx_req_ready", 32'(req_ready_o), 32'd0);
        rst_i = 1'b0;
        #1;
        check("rstx_release_ready", 32'(req_ready_o), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (resp_valid_o || busy_o) seen = 1'b1;
        end
        check("rstx_no_stale_resp", 32'(seen), 32'd0);
        $display("reset: DIV aborted mid-EXEC");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
